rram_drive_seq: RTL

Synthesizable drive sequencer that sits directly upstream of the 6×6 RRAM unit and generates its word-line, source-line, bit-line, set, back and label controls. On a start request it runs one training pass: transistor-on, initialization, feed-forward, error calculation, ramped weight-update pulses, then release. The bench-driven stimulus for the RRAM unit becomes a reusable, timed hardware block.

---
 rtl/rram_drive_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rram_drive_seq.sv
// Drive sequencer for the 6x6 RRAM unit: one start runs a full training pass
// (word-line on, init, feed-forward, error, ramped update, clear, release).
module rram_drive_seq #(
    parameter int unsigned N_LINES   = 6,
    parameter int unsigned PHASE_CYC = 10,
    parameter int unsigned UPD_STEPS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_LINES-1:0] x_in,
    input  logic               label_in,
    output logic               busy,
    output logic               done,
    output logic [N_LINES-1:0] Dwl,
    output logic [N_LINES-1:0] Dsl,
    output logic [N_LINES-1:0] Dbl,
    output logic               Dset,
    output logic               Dback,
    output logic               Dlabel
);

    localparam int unsigned CNT_W  = $clog2(PHASE_CYC) + 1;
    localparam int unsigned STEP_W = $clog2(UPD_STEPS) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(PHASE_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(UPD_STEPS);

    typedef enum logic [2:0] {
        StIdle, StWlOn, StInit, StFf, StErr, StUpd, StClr, StRel
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [N_LINES-1:0] x_q, x_d;
    logic               label_q, label_d;

    logic               busy_d, done_d, dset_d, dback_d, dlabel_d;
    logic [N_LINES-1:0] dwl_d, dsl_d, dbl_d;

    function automatic logic [N_LINES-1:0] therm(input logic [STEP_W-1:0] k);
        logic [N_LINES-1:0] t;
        t = '0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            t[i] = (i < 2 * int'(k));
        end
        return t;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        x_d     = x_q;
        label_d = label_q;
        done_d  = 1'b0;

        if (state_q == StIdle) begin
            if (start && !abort) begin
                state_d = StWlOn;
                cnt_d   = CNT_LOAD;
                step_d  = '0;
                x_d     = x_in;
                label_d = label_in;
            end
        end else if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
            step_d  = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = CNT_LOAD;
            unique case (state_q)
                StWlOn: state_d = StInit;
                StInit: state_d = StFf;
                StFf:   state_d = StErr;
                StErr: begin
                    state_d = StUpd;
                    step_d  = STEP_W'(1);
                end
                StUpd: begin
                    if (step_q == STEP_LAST) begin
                        state_d = StClr;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                StClr: state_d = StRel;
                // Release holds for two phase periods so a pass spans 7+UPD_STEPS phases.
                StRel: begin
                    if (step_q == '0) begin
                        step_d = STEP_W'(1);
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        step_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d   = (state_d != StIdle);
        dwl_d    = busy_d ? '1 : '0;
        dsl_d    = '0;
        dbl_d    = '0;
        dset_d   = 1'b0;
        dback_d  = 1'b0;
        dlabel_d = 1'b0;
        unique case (state_d)
            StIdle, StWlOn: ;
            StInit: begin
                dset_d = 1'b1;
                dbl_d  = '1;
            end
            StFf:  dsl_d = x_d;
            StErr: begin
                dsl_d    = x_d;
                dlabel_d = label_d;
            end
            StUpd: begin
                dsl_d    = x_d;
                dlabel_d = label_d;
                dback_d  = 1'b1;
                dbl_d    = therm(step_d);
            end
            StClr: begin
                dsl_d    = x_d;
                dlabel_d = label_d;
                dback_d  = 1'b1;
            end
            StRel: begin
                dsl_d    = x_d;
                dlabel_d = label_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            step_q  <= '0;
            x_q     <= '0;
            label_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Dwl     <= '0;
            Dsl     <= '0;
            Dbl     <= '0;
            Dset    <= 1'b0;
            Dback   <= 1'b0;
            Dlabel  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            x_q     <= x_d;
            label_q <= label_d;
            busy    <= busy_d;
            done    <= done_d;
            Dwl     <= dwl_d;
            Dsl     <= dsl_d;
            Dbl     <= dbl_d;
            Dset    <= dset_d;
            Dback   <= dback_d;
            Dlabel  <= dlabel_d;
        end
    end

endmodule
